// File: rtl/bip_exec_control_pkg.sv
// Shared definitions for the BIP execution controller.
//   state_e    : sequencer states (FETCH=0, DECODE=1, EXEC=2, HALT=3)
//   opcode_e   : architectural opcodes; encodings 8..31 are executed as NOP
//   writes_acc : true for opcodes that load the accumulator (LD..SUBI)
package bip_exec_control_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  typedef enum logic [4:0] {
    OP_HLT  = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7
  } opcode_e;

  function automatic logic writes_acc(input logic [4:0] op);
    return (op >= OP_LD) && (op <= OP_SUBI);
  endfunction

endpackage

// File: rtl/bip_alu.sv
// Combinational ALU for the BIP execution controller.
//   opcode       : in  5       instruction opcode
//   acc          : in  E_BITS  current accumulator value
//   rdata        : in  E_BITS  data memory read data
//   sext_operand : in  E_BITS  sign-extended immediate operand
//   result       : out E_BITS  next accumulator value (modulo 2^E_BITS)
// For opcodes that do not load the accumulator the result is the accumulator
// itself; the controller ignores it in that case.
module bip_alu
  import bip_exec_control_pkg::*;
#(
  parameter int E_BITS = 16
) (
  input  logic [4:0]        opcode,
  input  logic [E_BITS-1:0] acc,
  input  logic [E_BITS-1:0] rdata,
  input  logic [E_BITS-1:0] sext_operand,
  output logic [E_BITS-1:0] result
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    result = acc;
    case (opcode)
      OP_LD:   result = rdata;
      OP_LDI:  result = sext_operand;
      OP_ADD:  result = acc + rdata;
      OP_ADDI: result = acc + sext_operand;
      OP_SUB:  result = acc - rdata;
      OP_SUBI: result = acc - sext_operand;
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_exec_control.sv
// Fetch/decode/execute sequencer for the BIP datapath (feeds the accumulator).
//   i_clock      : in  1        clock, rising edge
//   i_reset      : in  1        synchronous, active-high reset
//   o_pc         : out PC_BITS  program memory address
//   i_instr      : in  E_BITS   program memory data, one cycle after o_pc
//   o_dmem_addr  : out 11       data memory address (operand field)
//   o_dmem_we    : out 1        data memory write strobe, one cycle
//   o_dmem_wdata : out E_BITS   data memory write data (the accumulator)
//   i_dmem_rdata : in  E_BITS   data memory read data, valid by the end of EXEC
//   i_acc        : in  E_BITS   current accumulator value
//   o_mux        : out E_BITS   next accumulator value
//   o_acc_enable : out 1        accumulator load strobe, one cycle
//   o_halted     : out 1        high while halted
// Every instruction takes FETCH -> DECODE -> EXEC. Results and strobes are
// registered at the rising edge that ends EXEC, so they are visible for the
// following cycle and the accumulator can take o_mux on the next falling edge.
module bip_exec_control
  import bip_exec_control_pkg::*;
#(
  parameter int E_BITS  = 16,
  parameter int PC_BITS = 11,
  parameter int OP_BITS = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  output logic [PC_BITS-1:0]         o_pc,
  input  logic [E_BITS-1:0]          i_instr,
  output logic [E_BITS-OP_BITS-1:0]  o_dmem_addr,
  output logic                       o_dmem_we,
  output logic [E_BITS-1:0]          o_dmem_wdata,
  input  logic [E_BITS-1:0]          i_dmem_rdata,
  input  logic [E_BITS-1:0]          i_acc,
  output logic [E_BITS-1:0]          o_mux,
  output logic                       o_acc_enable,
  output logic                       o_halted
);

  localparam int OPR_BITS = E_BITS - OP_BITS;

  // Declaration values match the reset values so the block behaves the same
  // when simulation or configuration starts without a reset pulse.
  state_e              state       = ST_FETCH;
  logic [E_BITS-1:0]   ir          = '0;
  logic [PC_BITS-1:0]  pc_q        = '0;
  logic [OPR_BITS-1:0] dmem_addr_q = '0;
  logic [E_BITS-1:0]   mux_q       = '0;
  logic                acc_en_q    = 1'b0;
  logic                we_q        = 1'b0;
  logic                halted_q    = 1'b0;

  logic [OP_BITS-1:0]  opcode;
  logic [OPR_BITS-1:0] operand;
  logic [E_BITS-1:0]   sext_operand;
  logic [E_BITS-1:0]   alu_result;

  assign opcode       = ir[E_BITS-1 -: OP_BITS];
  assign operand      = ir[OPR_BITS-1:0];
  assign sext_operand = {{OP_BITS{operand[OPR_BITS-1]}}, operand};

  bip_alu #(.E_BITS(E_BITS)) u_alu (
    .opcode       (opcode),
    .acc          (i_acc),
    .rdata        (i_dmem_rdata),
    .sext_operand (sext_operand),
    .result       (alu_result)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= ST_FETCH;
      ir          <= '0;
      pc_q        <= '0;
      dmem_addr_q <= '0;
      mux_q       <= '0;
      acc_en_q    <= 1'b0;
      we_q        <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every edge unless EXEC sets them.
      acc_en_q <= 1'b0;
      we_q     <= 1'b0;
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir          <= i_instr;
          dmem_addr_q <= i_instr[OPR_BITS-1:0];
          state       <= ST_EXEC;
        end
        ST_EXEC: begin
          if (opcode == OP_HLT) begin
            halted_q <= 1'b1;
            state    <= ST_HALT;
          end else begin
            pc_q  <= pc_q + 1'b1;
            state <= ST_FETCH;
            we_q  <= (opcode == OP_STO);
            if (writes_acc(opcode)) begin
              mux_q    <= alu_result;
              acc_en_q <= 1'b1;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
      endcase
    end
  end

  assign o_pc         = pc_q;
  assign o_dmem_addr  = dmem_addr_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_wdata = i_acc;
  assign o_mux        = mux_q;
  assign o_acc_enable = acc_en_q;
  assign o_halted     = halted_q;

endmodule

// File: tb/tb_bip_exec_control.sv
// Self-checking bench for bip_exec_control. Surrounds the DUT with a sync
// ROM, a data memory and an accumulator, and checks it against an
// instruction-level interpreter of the BIP ISA.
module tb_bip_exec_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] pc;
  logic [15:0] instr = '0;
  logic [10:0] dmem_addr;
  logic        dmem_we;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic [15:0] acc = '0;
  logic [15:0] mux;
  logic        acc_en;
  logic        halted;

  logic [15:0] rom    [0:2047];
  logic [15:0] dmem   [0:2047];
  logic [15:0] m_dmem [0:2047];

  int          n_tests = 0;
  int          n_fail  = 0;

  // Interpreter state
  int          m_pc;
  logic [15:0] m_acc;
  logic [15:0] m_mux;
  logic        m_halted;

  bip_exec_control dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .o_pc         (pc),
    .i_instr      (instr),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_we    (dmem_we),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_rdata (dmem_rdata),
    .i_acc        (acc),
    .o_mux        (mux),
    .o_acc_enable (acc_en),
    .o_halted     (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc];
  assign dmem_rdata = dmem[dmem_addr];
  always @(negedge clk) begin
    if (rst) acc <= '0;
    else if (acc_en) acc <= mux;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; data memory writes commit on the edge using values
  // sampled before it. Returns 1 time unit after the rising edge.
  task automatic tick();
    logic        we_s;
    logic [10:0] a_s;
    logic [15:0] d_s;
    we_s = dmem_we;
    a_s  = dmem_addr;
    d_s  = dmem_wdata;
    @(posedge clk);
    if (we_s) dmem[a_s] = d_s;
    #1;
  endtask

  function automatic logic [15:0] enc(input int op, input int opr);
    return {5'(op), 11'(opr)};
  endfunction

  task automatic fill_rom_nop();
    for (int i = 0; i < 2048; i++) rom[i] = enc(8, 0);
  endtask

  task automatic init_dmem();
    logic [15:0] v;
    for (int i = 0; i < 2048; i++) begin
      v = 16'($urandom);
      dmem[i]   = v;
      m_dmem[i] = v;
    end
  endtask

  task automatic set_dmem(input int a, input logic [15:0] v);
    dmem[a]   = v;
    m_dmem[a] = v;
  endtask

  task automatic model_reset();
    m_pc     = 0;
    m_acc    = '0;
    m_mux    = '0;
    m_halted = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_pc", 16'(pc), 16'h0000);
    check("rst_mux", mux, 16'h0000);
    check("rst_acc_en", 16'(acc_en), 16'h0000);
    check("rst_we", 16'(dmem_we), 16'h0000);
    check("rst_halted", 16'(halted), 16'h0000);
    check("rst_addr", 16'(dmem_addr), 16'h0000);
    rst = 1'b0;
    model_reset();
  endtask

  // Execute one instruction in the interpreter and check the DUT after its EXEC edge.
  task automatic run_one();
    logic [15:0] ins, sx, rd, e_wdata;
    logic [4:0]  op;
    logic [10:0] opr;
    logic        e_en, e_we;
    tick();
    check("strobe_len_en", 16'(acc_en), 16'h0000);
    check("strobe_len_we", 16'(dmem_we), 16'h0000);
    tick();
    tick();
    ins     = rom[m_pc];
    op      = ins[15:11];
    opr     = ins[10:0];
    sx      = 16'($signed(opr));
    rd      = m_dmem[opr];
    e_en    = 1'b0;
    e_we    = 1'b0;
    e_wdata = m_acc;
    case (op)
      5'd0: m_halted = 1'b1;
      5'd1: begin e_we = 1'b1; m_dmem[opr] = m_acc; end
      5'd2: m_mux = rd;
      5'd3: m_mux = sx;
      5'd4: m_mux = m_acc + rd;
      5'd5: m_mux = m_acc + sx;
      5'd6: m_mux = m_acc - rd;
      5'd7: m_mux = m_acc - sx;
      default: ;
    endcase
    if (op >= 5'd2 && op <= 5'd7) begin
      e_en  = 1'b1;
      m_acc = m_mux;
    end
    if (op != 5'd0) m_pc = (m_pc + 1) % 2048;
    check("exec_pc", 16'(pc), 16'(m_pc));
    check("exec_mux", mux, m_mux);
    check("exec_acc_en", 16'(acc_en), 16'(e_en));
    check("exec_we", 16'(dmem_we), 16'(e_we));
    check("exec_addr", 16'(dmem_addr), 16'(opr));
    check("exec_halted", 16'(halted), 16'(m_halted));
    if (e_we) check("exec_wdata", dmem_wdata, e_wdata);
  endtask

  task automatic check_halt_hold();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_pc", 16'(pc), 16'(m_pc));
      check("halt_flag", 16'(halted), 16'h0001);
      check("halt_acc_en", 16'(acc_en), 16'h0000);
      check("halt_we", 16'(dmem_we), 16'h0000);
      check("halt_mux", mux, m_mux);
    end
  endtask

  logic [15:0] exp_a [0:12];

  initial begin
    // Power-up values before any reset
    #1;
    check("init_pc", 16'(pc), 16'h0000);
    check("init_mux", mux, 16'h0000);
    check("init_acc_en", 16'(acc_en), 16'h0000);
    check("init_halted", 16'(halted), 16'h0000);

    // Directed program: immediates, wrap, store, add/sub from memory, NOP, halt
    fill_rom_nop();
    init_dmem();
    set_dmem('h020, 16'h00FF);
    set_dmem('h030, 16'h1234);
    rom[0]  = enc(3, 5);
    rom[1]  = enc(3, 8);
    rom[2]  = enc(5, 'h7FF);
    rom[3]  = enc(3, 0);
    rom[4]  = enc(7, 1);
    rom[5]  = enc(2, 'h030);
    rom[6]  = enc(1, 'h010);
    rom[7]  = enc(3, 1);
    rom[8]  = enc(4, 'h020);
    rom[9]  = enc(2, 'h020);
    rom[10] = enc(9, 'h155);
    rom[11] = enc(6, 'h010);
    rom[12] = enc(0, 0);
    exp_a = '{16'h0005, 16'h0008, 16'h0007, 16'h0000, 16'hFFFF, 16'h1234, 16'h1234,
              16'h0001, 16'h0100, 16'h00FF, 16'h00FF, 16'hEECB, 16'hEECB};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      run_one();
      check("dir_mux", mux, exp_a[i]);
    end
    check("dir_sto_mem", dmem['h010], 16'h1234);
    check("dir_halt_pc", 16'(pc), 16'h000C);
    check_halt_hold();

    // HLT at pc 3 after NOP encodings 9 and 31
    fill_rom_nop();
    rom[0] = enc(3, 1);
    rom[1] = enc(9, 0);
    rom[2] = enc(31, 'h7FF);
    rom[3] = enc(0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) run_one();
    check("hlt3_pc", 16'(pc), 16'h0003);
    check("hlt3_mux", mux, 16'h0001);
    check_halt_hold();

    // Reset in the EXEC cycle of an ADDI
    fill_rom_nop();
    rom[0] = enc(3, 8);
    rom[1] = enc(5, 3);
    do_reset();
    run_one();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_acc_en", 16'(acc_en), 16'h0000);
    check("midrst_pc", 16'(pc), 16'h0000);
    check("midrst_mux", mux, 16'h0000);
    rst = 1'b0;
    model_reset();
    run_one();
    check("midrst_refetch", mux, 16'h0008);
    run_one();
    check("midrst_addi", mux, 16'h000B);

    // Random program without HLT, long enough to wrap the PC
    for (int i = 0; i < 2048; i++)
      rom[i] = enc($urandom_range(1, 31),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : $urandom_range(0, 2047));
    init_dmem();
    do_reset();
    for (int i = 0; i < 2048; i++) run_one();
    check("pc_wrap", 16'(pc), 16'h0000);
    for (int i = 0; i < 12; i++) run_one();

    // Random program ending in HLT
    for (int i = 0; i < 2048; i++)
      rom[i] = enc($urandom_range(1, 15), $urandom_range(0, 31));
    rom[$urandom_range(20, 40)] = enc(0, $urandom_range(0, 2047));
    init_dmem();
    do_reset();
    for (int i = 0; i < 41 && !m_halted; i++) run_one();
    check("rand_halted", 16'(halted), 16'h0001);
    check_halt_hold();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
